midi_note_tracker: RTL

//  Parses the raw MIDI byte stream from the UART receiver into note-on/note-off events.

---
 rtl/midi_note_tracker_if.sv | 21 ++
 rtl/midi_note_tracker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/midi_note_tracker_if.sv
// MIDI byte input and note/event outputs between the UART side and the tracker.
interface midi_note_tracker_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] midi_data;
    logic       midi_valid;
    logic [6:0] velocity;
    logic       event_valid;
    logic       event_on;
    logic [6:0] event_note;

    modport master (
        output rx_data, rx_valid,
        input  midi_data, midi_valid, velocity, event_valid, event_on, event_note
    );

    modport slave (
        input  rx_data, rx_valid,
        output midi_data, midi_valid, velocity, event_valid, event_on, event_note
    );
endinterface

// File: rtl/midi_note_tracker.sv
// MIDI byte parser feeding a last-note-priority held-note stack (monophonic gate/note/velocity).
// Latency: completing data byte at edge N -> stack, outputs and event pulse at edge N+1.
// No backpressure: a byte may arrive every cycle and every event is applied.
module midi_note_tracker #(
    parameter int CHANNEL     = 0,
    parameter bit OMNI        = 1'b0,
    parameter int STACK_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    midi_note_tracker_if.slave bus
);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, WAIT_D1, WAIT_D2, SKIP1, SKIP2} state_t;

    state_t        state, state_nx;
    logic [7:0]    status;
    logic [6:0]    note;
    logic          latch_status, latch_note, fire;

    logic          pend_vld, pend_on;
    logic [6:0]    pend_note, pend_vel;

    logic [6:0]    st_note [STACK_DEPTH];
    logic [6:0]    st_vel  [STACK_DEPTH];
    logic [CW-1:0] cnt;

    logic [6:0]    t_note [STACK_DEPTH];
    logic [6:0]    t_vel  [STACK_DEPTH];
    logic [CW-1:0] t_cnt;
    logic [6:0]    n_note [STACK_DEPTH];
    logic [6:0]    n_vel  [STACK_DEPTH];
    logic [CW-1:0] n_cnt;
    logic          found;
    logic [CW-1:0] pos;
    logic [6:0]    top_note, top_vel;

    // Data-byte state a status byte leads to; off-channel note messages are skipped, not dropped.
    function automatic state_t first_state(input logic [7:0] s);
        logic ch_ok;
        ch_ok = OMNI || (s[3:0] == 4'(CHANNEL));
        case (s[6:4])
            3'd0, 3'd1: return ch_ok ? WAIT_D1 : SKIP2;
            3'd4, 3'd5: return SKIP1;
            default:    return SKIP2;
        endcase
    endfunction

    always_comb begin
        state_nx     = state;
        latch_status = 1'b0;
        latch_note   = 1'b0;
        fire         = 1'b0;
        if (bus.rx_valid && bus.rx_data[7:3] != 5'b11111) begin
            if (bus.rx_data[7]) begin
                if (bus.rx_data[6:4] != 3'b111) begin
                    latch_status = 1'b1;
                    state_nx     = first_state(bus.rx_data);
                end else begin
                    state_nx = IDLE;
                end
            end else begin
                case (state)
                    WAIT_D1: begin latch_note = 1'b1; state_nx = WAIT_D2; end
                    WAIT_D2: begin fire = 1'b1;       state_nx = WAIT_D1; end
                    SKIP2:   state_nx = SKIP1;
                    SKIP1:   state_nx = first_state(status);
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            status    <= '0;
            note      <= '0;
            pend_vld  <= 1'b0;
            pend_on   <= 1'b0;
            pend_note <= '0;
            pend_vel  <= '0;
        end else begin
            state    <= state_nx;
            pend_vld <= fire;
            if (latch_status) status <= bus.rx_data;
            if (latch_note)   note   <= bus.rx_data[6:0];
            if (fire) begin
                pend_on   <= status[4] && (bus.rx_data[6:0] != 7'd0);
                pend_note <= note;
                pend_vel  <= bus.rx_data[6:0];
            end
        end
    end

    // Remove pend_note if held, then (for note-on) push it on top, evicting the bottom when full.
    always_comb begin
        t_note = st_note;
        t_vel  = st_vel;
        t_cnt  = cnt;
        found  = 1'b0;
        pos    = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!found && CW'(i) < cnt && st_note[i] == pend_note) begin
                found = 1'b1;
                pos   = CW'(i);
            end
        end
        if (found) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                if (CW'(i) >= pos) begin
                    t_note[i] = st_note[i+1];
                    t_vel[i]  = st_vel[i+1];
                end
            end
            t_cnt = cnt - 1'b1;
        end
        n_note = t_note;
        n_vel  = t_vel;
        n_cnt  = t_cnt;
        if (pend_on) begin
            if (t_cnt == CW'(STACK_DEPTH)) begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                    n_note[i] = t_note[i+1];
                    n_vel[i]  = t_vel[i+1];
                end
                n_note[STACK_DEPTH-1] = pend_note;
                n_vel[STACK_DEPTH-1]  = pend_vel;
            end else begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (CW'(i) == t_cnt) begin
                        n_note[i] = pend_note;
                        n_vel[i]  = pend_vel;
                    end
                end
                n_cnt = t_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt             <= '0;
            bus.event_valid <= 1'b0;
            bus.event_on    <= 1'b0;
            bus.event_note  <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                st_note[i] <= '0;
                st_vel[i]  <= '0;
            end
        end else begin
            bus.event_valid <= pend_vld;
            if (pend_vld) begin
                st_note        <= n_note;
                st_vel         <= n_vel;
                cnt            <= n_cnt;
                bus.event_on   <= pend_on;
                bus.event_note <= pend_note;
            end
        end
    end

    always_comb begin
        top_note = '0;
        top_vel  = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (cnt == CW'(i + 1)) begin
                top_note = st_note[i];
                top_vel  = st_vel[i];
            end
        end
    end

    assign bus.midi_valid = (cnt != '0);
    assign bus.midi_data  = {1'b0, top_note};
    assign bus.velocity   = top_vel;
endmodule
